ldpc15_encoder: RTL and testbench



---
 rtl/ldpc15_encoder.sv | 155 +++++++++++++++
 tb/tb_ldpc15_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc15_encoder.sv
// ldpc15_encoder: systematic encoder for the (15,7) cyclic EG-LDPC code.
// The message d lands in c[6:0]; parity c[14:7] is grown with the code's
// recurrence c[k+7] = c[k] ^ c[k+1] ^ c[k+3], PAR_PER_CYCLE bits per ENC cycle.
// Optional build macro ENC_SELF_CHECK_EN adds a syndrome check of every
// finished codeword (sticky chk_err) at the cost of one extra cycle of latency.
module ldpc15_encoder #(
    parameter int PAR_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  d,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] c,
    output logic        busy,
    output logic        chk_err
);

    // Only power-of-two widths that evenly split the 8 parity bits make sense.
    generate
        if (PAR_PER_CYCLE != 1 && PAR_PER_CYCLE != 2 &&
            PAR_PER_CYCLE != 4 && PAR_PER_CYCLE != 8) begin : g_bad_par
            $error("ldpc15_encoder: PAR_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam int         STEPS    = 8 / PAR_PER_CYCLE;
    localparam logic [2:0] LAST_CNT = 3'(STEPS - 1);

    // DONE waits SETTLE_LAST+1 edges before raising out_valid; the extra edge
    // in the self-check build is where the syndrome gets evaluated.
`ifdef ENC_SELF_CHECK_EN
    localparam logic [1:0] SETTLE_LAST = 2'd1;
`else
    localparam logic [1:0] SETTLE_LAST = 2'd0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [1:0]  settle;
    logic [14:0] c_step;

    // State register; reset abandons whatever message was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, run STEPS parity cycles, hold in DONE
    // until the consumer takes the codeword.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = ENC;
            ENC:  if (cnt == LAST_CNT) state_next = DONE;
            DONE: if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state.
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // One ENC step: the parity bits owned by this cnt value are produced in
    // increasing k, so later bits in the same step see earlier ones already
    // updated (each bit only depends on lower indices).
    always_comb begin
        c_step = c;
        for (int k = 0; k < 8; k++) begin
            if (cnt == 3'(k / PAR_PER_CYCLE)) begin
                c_step[k + 7] = c_step[k] ^ c_step[k + 1] ^ c_step[k + 3];
            end
        end
    end

    // Codeword register, step counter and output-valid handshake bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c         <= 15'h0000;
            cnt       <= 3'd0;
            settle    <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c      <= {8'h00, d};
                        cnt    <= 3'd0;
                        settle <= 2'd0;
                    end
                end
                ENC: begin
                    c <= c_step;
                    if (cnt != LAST_CNT) begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (out_valid) begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end else if (settle == SETTLE_LAST) begin
                        out_valid <= 1'b1;
                    end else begin
                        settle <= settle + 2'd1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ENC_SELF_CHECK_EN
    // Full 15-row syndrome: row s checks positions s, s+1, s+3, s+7 (mod 15).
    function automatic logic [14:0] syndrome(input logic [14:0] cw);
        logic [14:0] s;
        s = '0;
        for (int r = 0; r < 15; r++) begin
            s[r] = cw[r] ^ cw[(r + 1) % 15] ^ cw[(r + 3) % 15] ^ cw[(r + 7) % 15];
        end
        return s;
    endfunction

    // Sticky error flag, evaluated once on the first DONE cycle of each codeword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
        end else if (state == DONE && !out_valid && settle == 2'd0 &&
                     (|syndrome(c))) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ldpc15_encoder.sv
// tb_ldpc15_encoder: self-checking bench for ldpc15_encoder.
// Four encoders (P = 1, 2, 4, 8) share clock and reset; each codeword is
// compared against a reference built from the parity-check rows.
`timescale 1ns/1ps
module tb_ldpc15_encoder;

`ifdef ENC_SELF_CHECK_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [6:0]  d         [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [14:0] c         [4];
    logic        busy      [4];
    logic        chk_err   [4];

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        exp_chk  [4];
    logic [14:0] forced_val;

    ldpc15_encoder #(.PAR_PER_CYCLE(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .d(d[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .c(c[0]),
        .busy(busy[0]), .chk_err(chk_err[0]));
    ldpc15_encoder #(.PAR_PER_CYCLE(2)) u_p2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .d(d[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .c(c[1]),
        .busy(busy[1]), .chk_err(chk_err[1]));
    ldpc15_encoder #(.PAR_PER_CYCLE(4)) u_p4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .d(d[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .c(c[2]),
        .busy(busy[2]), .chk_err(chk_err[2]));
    ldpc15_encoder #(.PAR_PER_CYCLE(8)) u_p8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .d(d[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .c(c[3]),
        .busy(busy[3]), .chk_err(chk_err[3]));

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Safety net so a stuck handshake can never hang the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    // Reference encoder: systematic message then parity from the rule
    // c[k+7] = c[k] + c[k+1] + c[k+3] (mod 2).
    function automatic logic [14:0] model_encode(input logic [6:0] msg);
        int          cw [15];
        logic [14:0] r;
        for (int i = 0; i < 7; i++) cw[i] = int'(msg[i]);
        for (int k = 0; k < 8; k++) cw[k + 7] = (cw[k] + cw[k + 1] + cw[k + 3]) % 2;
        r = '0;
        for (int i = 0; i < 15; i++) r[i] = (cw[i] == 1);
        return r;
    endfunction

    // Number of parity-check rows (of 15) a word violates.
    function automatic int row_violations(input logic [14:0] cw);
        int bad = 0;
        for (int s = 0; s < 15; s++) begin
            int w;
            w = int'(cw[s]) + int'(cw[(s + 1) % 15]) + int'(cw[(s + 3) % 15]) +
                int'(cw[(s + 7) % 15]);
            if ((w % 2) != 0) bad++;
        end
        return bad;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Present one message on encoder i and complete the input handshake.
    task automatic applyStimulus(input int i, input logic [6:0] msg);
        int waited = 0;
        while (!in_ready[i] && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 50) checkOutput("in_ready_timeout", 32'(waited), 32'd0);
        in_valid[i] = 1'b1;
        d[i]        = msg;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        d[i]        = 7'($urandom);
    endtask

    // Count edges from the input handshake until out_valid rises (bounded).
    task automatic waitValid(input int i, output int lat);
        lat = 0;
        while (!out_valid[i] && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full transaction on encoder i with out_ready already high.
    task automatic runOne(input int i, input logic [6:0] msg);
        int          lat;
        logic [14:0] expc;
        expc = model_encode(msg);
        applyStimulus(i, msg);
        waitValid(i, lat);
        checkOutput($sformatf("p%0d_lat_d%02h", 1 << i, msg), 32'(lat), 32'((8 >> i) + 1 + EXTRA));
        checkOutput($sformatf("p%0d_c_d%02h", 1 << i, msg), 32'(c[i]), 32'(expc));
        checkOutput($sformatf("p%0d_rows_d%02h", 1 << i, msg), 32'(row_violations(c[i])), 32'd0);
        checkOutput($sformatf("p%0d_sys_d%02h", 1 << i, msg), 32'(c[i][6:0]), 32'(msg));
        checkOutput($sformatf("p%0d_chk_d%02h", 1 << i, msg), 32'(chk_err[i]), 32'(exp_chk[i]));
        @(posedge clk); #1;
        checkOutput($sformatf("p%0d_idle_d%02h", 1 << i, msg), 32'(in_ready[i]), 32'd1);
    endtask

    // Directed scenarios first, then the randomized full-message sweep.
    initial begin
        logic [14:0] held;
        logic [6:0]  msg;
        logic [6:0]  order [128];
        int          lat;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            d[i]         = 7'h00;
            out_ready[i] = 1'b1;
            exp_chk[i]   = 1'b0;
        end
        forced_val = '0;
        #23 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] reset state");
        for (int i = 0; i < 4; i++) begin
            checkOutput("rst_in_ready", 32'(in_ready[i]), 32'd1);
            checkOutput("rst_busy", 32'(busy[i]), 32'd0);
            checkOutput("rst_out_valid", 32'(out_valid[i]), 32'd0);
            checkOutput("rst_c", 32'(c[i]), 32'h0);
            checkOutput("rst_chk_err", 32'(chk_err[i]), 32'd0);
        end

        $display("[TB] directed codewords");
        applyStimulus(0, 7'h01);
        checkOutput("enc_busy", 32'(busy[0]), 32'd1);
        checkOutput("enc_in_ready", 32'(in_ready[0]), 32'd0);
        waitValid(0, lat);
        checkOutput("d01_c_const", 32'(c[0]), 32'h6881);
        checkOutput("d01_lat", 32'(lat), 32'(9 + EXTRA));
        @(posedge clk); #1;
        runOne(0, 7'h7F);
        checkOutput("d7f_c_const", 32'(model_encode(7'h7F)), 32'h7FFF);
        runOne(0, 7'h00);
        runOne(3, 7'h01);

        $display("[TB] backpressure");
        out_ready[0] = 1'b0;
        msg = 7'($urandom);
        applyStimulus(0, msg);
        waitValid(0, lat);
        held = model_encode(msg);
        in_valid[0] = 1'b1;
        d[0]        = ~msg;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            checkOutput("bp_c_stable", 32'(c[0]), 32'(held));
            checkOutput("bp_out_valid", 32'(out_valid[0]), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready[0]), 32'd0);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_busy", 32'(busy[0]), 32'd0);
        checkOutput("bp_release_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("bp_c_kept", 32'(c[0]), 32'(held));

        $display("[TB] reset mid-encode");
        applyStimulus(0, 7'h7F);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("arst_c", 32'(c[0]), 32'h0);
        checkOutput("arst_busy", 32'(busy[0]), 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rel_in_ready", 32'(in_ready[0]), 32'd1);
        checkOutput("rel_busy", 32'(busy[0]), 32'd0);
        checkOutput("rel_c", 32'(c[0]), 32'h0);
        checkOutput("rel_out_valid", 32'(out_valid[0]), 32'd0);

`ifdef ENC_SELF_CHECK_EN
        $display("[TB] self-check with corrupted parity");
        out_ready[0] = 1'b0;
        msg = 7'($urandom);
        forced_val = model_encode(msg) ^ 15'h0200;
        applyStimulus(0, msg);
        repeat (7) @(posedge clk);
        #1;
        force u_p1.c = forced_val;
        @(posedge clk); #1;
        release u_p1.c;
        waitValid(0, lat);
        checkOutput("sc_chk_err_set", 32'(chk_err[0]), 32'd1);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        exp_chk[0] = 1'b1;
        runOne(0, 7'($urandom));
        checkOutput("sc_chk_err_sticky", 32'(chk_err[0]), 32'd1);
        #3 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        exp_chk[0] = 1'b0;
        @(posedge clk); #1;
        checkOutput("sc_chk_err_cleared", 32'(chk_err[0]), 32'd0);
`endif

        $display("[TB] all-message sweep");
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 128; j++) order[j] = 7'(j);
            for (int j = 127; j > 0; j--) begin
                int r;
                r = int'($urandom_range(j, 0));
                msg      = order[j];
                order[j] = order[r];
                order[r] = msg;
            end
            for (int j = 0; j < 128; j++) runOne(i, order[j]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
